// File: rtl/adder_arbiter.sv
// adder_arbiter -- round-robin arbiter in front of one shared NBIT adder.
//
// Requesters present operand pairs on req_valid/req_a/req_b. One requester
// is granted in IDLE (combinational one-hot req_ready), its operands are
// latched, summed in ADD and held on rsp_* in RESP until rsp_ready.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid[NREQ]     requester i has an operand pair
//   req_a/req_b         operands, requester i at [i*NBIT +: NBIT]
//   req_ready[NREQ]     one-hot grant, IDLE only
//   rsp_valid/rsp_ready response handshake
//   rsp_sum/rsp_cout    (a+b) mod 2^NBIT and carry out
//   rsp_id              index of the requester owning the response
//   busy                high whenever not IDLE
module adder_arbiter #(
  parameter int NBIT = 32,
  parameter int NREQ = 4,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*NBIT-1:0] req_a,
  input  logic [NREQ*NBIT-1:0] req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [NBIT-1:0]      rsp_sum,
  output logic                 rsp_cout,
  output logic [IDW-1:0]       rsp_id,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, ADD, RESP} state_t;

  state_t                    state, state_nxt;
  logic [IDW-1:0]            ptr, gnt_idx, op_id;
  logic [NBIT-1:0]           op_a, op_b;
  logic [NREQ-1:0]           ptr_mask, hi_valid;
  logic                      gnt_any, grant;
  logic [NBIT:0]             add_out;
  logic [NREQ-1:0][NBIT-1:0] a_arr, b_arr;

  assign a_arr = req_a;
  assign b_arr = req_b;

  // Bits at or above the pointer. Requests there win first; if none are
  // pending, the lowest pending request overall wins, which is the wrap.
  assign ptr_mask = ~((NREQ'(1) << ptr) - NREQ'(1));
  assign hi_valid = req_valid & ptr_mask;
  assign gnt_any  = |req_valid;

  always_comb begin
    gnt_idx = '0;
    for (int i = NREQ-1; i >= 0; i--)
      if (req_valid[i]) gnt_idx = IDW'(i);
    for (int i = NREQ-1; i >= 0; i--)
      if (hi_valid[i]) gnt_idx = IDW'(i);
  end

  assign grant = (state == IDLE) && gnt_any;

  // The single shared adder, carry-in 0.
  assign add_out = {1'b0, op_a} + {1'b0, op_b};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_any) state_nxt = ADD;
      ADD:     state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs. req_ready is also gated by rst_n so no grant is visible while
  // reset is held, even with requests pending.
  always_comb begin
    req_ready = '0;
    if (grant && rst_n) req_ready = NREQ'(1) << gnt_idx;
    busy = (state != IDLE);
  end

  // Operand latch, pointer and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_id     <= '0;
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_id    <= '0;
    end else begin
      if (grant) begin
        op_a  <= a_arr[gnt_idx];
        op_b  <= b_arr[gnt_idx];
        op_id <= gnt_idx;
        ptr   <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
      end
      if (state == ADD) begin
        rsp_sum   <= add_out[NBIT-1:0];
        rsp_cout  <= add_out[NBIT];
        rsp_id    <= op_id;
        rsp_valid <= 1'b1;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
module tb_adder_arbiter;
  localparam int NBIT = 32;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid, req_ready;
  logic [NREQ*NBIT-1:0] req_a, req_b;
  logic                 rsp_valid, rsp_ready, rsp_cout, busy;
  logic [NBIT-1:0]      rsp_sum;
  logic [IDW-1:0]       rsp_id;

  int total = 0;
  int bad   = 0;

  logic [NBIT-1:0] qa [NREQ][$];
  logic [NBIT-1:0] qb [NREQ][$];

  always #5 clk = ~clk;

  adder_arbiter #(.NBIT(NBIT), .NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_id(rsp_id), .busy(busy)
  );

  task automatic set_op(input int i, input logic [NBIT-1:0] a, input logic [NBIT-1:0] b);
    req_a[i*NBIT +: NBIT] = a;
    req_b[i*NBIT +: NBIT] = b;
  endtask

  // Returns just after a falling edge with reset released.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drives one request from requester idx with rsp_ready high and returns
  // the response; ok=0 if none appeared in the cycle budget.
  task automatic run_txn(input int idx, input logic [NBIT-1:0] a, input logic [NBIT-1:0] b,
                         output bit ok, output logic [NBIT-1:0] s, output logic c,
                         output logic [IDW-1:0] id);
    bit acc;
    ok = 0; s = '0; c = 1'b0; id = '0;
    set_op(idx, a, b);
    req_valid = NREQ'(1) << idx;
    rsp_ready = 1'b1;
    for (int n = 0; n < 12 && !ok; n++) begin
      #1;
      acc = (req_ready != '0);
      if (rsp_valid) begin s = rsp_sum; c = rsp_cout; id = rsp_id; ok = 1; end
      @(negedge clk);
      if (acc) req_valid = '0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    req_valid = '1; req_a = {NREQ{32'h1234_5678}}; req_b = {NREQ{32'h1111_1111}};
    rsp_ready = 1'b1;
    #2;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", rsp_valid); end
    total++; if (rsp_sum !== '0) begin bad++; $display("FAIL rst_sum got=%h exp=0", rsp_sum); end
    total++; if (rsp_cout !== 1'b0) begin bad++; $display("FAIL rst_cout got=%b exp=0", rsp_cout); end
    total++; if (rsp_id !== '0) begin bad++; $display("FAIL rst_id got=%0d exp=0", rsp_id); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (req_ready !== '0) begin bad++; $display("FAIL rst_ready got=%b exp=0", req_ready); end
  endtask

  task automatic test_single();
    do_reset();
    set_op(0, 32'h5, 32'h3);
    req_valid = 4'b0001; rsp_ready = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_grant got=%b exp=0001", req_ready); end
    @(negedge clk); req_valid = '0; #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL single_add_ready got=%b exp=0000", req_ready); end
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL single_add_state got=v%b/b%b exp=v0/b1", rsp_valid, busy); end
    @(negedge clk); #1;
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL single_rsp_valid got=%b exp=1", rsp_valid); end
    total++; if (rsp_sum !== 32'h8 || rsp_cout !== 1'b0 || rsp_id !== 2'd0)
      begin bad++; $display("FAIL single_rsp got=%h/%b/%0d exp=8/0/0", rsp_sum, rsp_cout, rsp_id); end
    @(negedge clk); #1;
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_done got=v%b/b%b exp=v0/b0", rsp_valid, busy); end
  endtask

  task automatic test_overflow();
    bit ok; logic [NBIT-1:0] s; logic c; logic [IDW-1:0] id;
    do_reset();
    run_txn(0, 32'hFFFF_FFFF, 32'h1, ok, s, c, id);
    total++; if (!ok || s !== 32'h0 || c !== 1'b1)
      begin bad++; $display("FAIL ovf_ff_1 got=ok%0d %h/%b exp=0/1", ok, s, c); end
    run_txn(1, 32'h8000_0000, 32'h8000_0000, ok, s, c, id);
    total++; if (!ok || s !== 32'h0 || c !== 1'b1 || id !== 2'd1)
      begin bad++; $display("FAIL ovf_80_80 got=ok%0d %h/%b id%0d exp=0/1 id1", ok, s, c, id); end
  endtask

  task automatic test_round_robin();
    logic [NBIT-1:0] ra [NREQ];
    logic [NBIT-1:0] rb [NREQ];
    logic [NBIT:0]   t;
    int order [5] = '{0, 1, 2, 3, 0};
    int ng = 0, nr = 0, last = 0;
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      ra[i] = $urandom; rb[i] = $urandom; set_op(i, ra[i], rb[i]);
    end
    req_valid = '1; rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && !(ng == 5 && nr == 5); cyc++) begin
      #1;
      if (req_ready != '0) begin
        total++;
        if (ng >= 5) begin bad++; $display("FAIL rr_extra_grant got=%b", req_ready); end
        else if (req_ready !== (NREQ'(1) << order[ng]))
          begin bad++; $display("FAIL rr_grant%0d got=%b exp=idx%0d", ng, req_ready, order[ng]); end
        if (ng > 0) begin
          total++; if (cyc - last !== 3) begin bad++; $display("FAIL rr_spacing got=%0d exp=3", cyc - last); end
        end
        last = cyc; ng++;
      end
      if (rsp_valid) begin
        total++;
        if (nr >= 5) begin bad++; $display("FAIL rr_extra_rsp id=%0d", rsp_id); end
        else begin
          t = {1'b0, ra[order[nr]]} + {1'b0, rb[order[nr]]};
          if (rsp_id !== IDW'(order[nr]) || rsp_sum !== t[NBIT-1:0] || rsp_cout !== t[NBIT])
            begin bad++; $display("FAIL rr_rsp%0d got=id%0d %h/%b exp=id%0d %h/%b", nr, rsp_id, rsp_sum, rsp_cout, order[nr], t[NBIT-1:0], t[NBIT]); end
        end
        nr++;
      end
      @(negedge clk);
    end
    total++; if (!(ng == 5 && nr == 5)) begin bad++; $display("FAIL rr_timeout got=g%0d/r%0d exp=5/5", ng, nr); end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    logic [NBIT-1:0] a, b, s0;
    logic [NBIT:0]   t;
    logic            c0;
    logic [IDW-1:0]  id0;
    do_reset();
    a = $urandom; b = $urandom; t = {1'b0, a} + {1'b0, b};
    set_op(1, a, b); req_valid = 4'b0010; rsp_ready = 1'b0;
    @(negedge clk); req_valid = 4'b0001; set_op(0, 32'h10, 32'h20);
    @(negedge clk); #1;
    s0 = rsp_sum; c0 = rsp_cout; id0 = rsp_id;
    total++; if (rsp_valid !== 1'b1 || s0 !== t[NBIT-1:0] || c0 !== t[NBIT] || id0 !== 2'd1)
      begin bad++; $display("FAIL bp_first got=v%b %h/%b id%0d exp=v1 %h/%b id1", rsp_valid, s0, c0, id0, t[NBIT-1:0], t[NBIT]); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      total++; if (rsp_valid !== 1'b1 || rsp_sum !== t[NBIT-1:0] || rsp_cout !== t[NBIT] || rsp_id !== 2'd1)
        begin bad++; $display("FAIL bp_hold%0d got=v%b %h/%b id%0d", k, rsp_valid, rsp_sum, rsp_cout, rsp_id); end
      total++; if (req_ready !== '0 || busy !== 1'b1)
        begin bad++; $display("FAIL bp_stall%0d got=r%b/b%b exp=r0000/b1", k, req_ready, busy); end
    end
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b0)
      begin bad++; $display("FAIL bp_release got=v%b/b%b exp=v0/b0", rsp_valid, busy); end
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL bp_next_grant got=%b exp=0001", req_ready); end
    @(negedge clk); req_valid = '0; #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL bp_next_busy got=%b exp=1", busy); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_op(2, 32'hDEAD_BEEF, 32'h1); req_valid = 4'b0100; rsp_ready = 1'b1;
    @(negedge clk); req_valid = '1;  // block now in ADD, pointer at 3
    #2 rst_n = 1'b0; #1;
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== '0)
      begin bad++; $display("FAIL rmid_ctrl got=v%b b%b r%b exp=0/0/0", rsp_valid, busy, req_ready); end
    total++; if (rsp_sum !== '0 || rsp_cout !== 1'b0 || rsp_id !== '0)
      begin bad++; $display("FAIL rmid_data got=%h/%b/%0d exp=0/0/0", rsp_sum, rsp_cout, rsp_id); end
    @(negedge clk); rst_n = 1'b1; req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++; if (rsp_valid !== 1'b0 || busy !== 1'b0)
        begin bad++; $display("FAIL rmid_after%0d got=v%b/b%b exp=v0/b0", k, rsp_valid, busy); end
      @(negedge clk);
    end
    req_valid = '1; #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rmid_ptr got=%b exp=0001", req_ready); end
    @(negedge clk); req_valid = '0;
  endtask

  task automatic test_sparse_wrap();
    do_reset();
    rsp_ready = 1'b1;
    set_op(2, 32'h2, 32'h2); req_valid = 4'b0100; #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL wrap_setup got=%b exp=0100", req_ready); end
    @(negedge clk); req_valid = '0;
    repeat (2) @(negedge clk);
    set_op(1, 32'h1, 32'h1); req_valid = 4'b0010; #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL wrap_grant got=%b exp=0010", req_ready); end
    @(negedge clk); req_valid = '0;
    repeat (2) @(negedge clk);
    req_valid = 4'b0110; #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL wrap_ptr2 got=%b exp=0100", req_ready); end
    @(negedge clk); req_valid = '0;
  endtask

  // Transaction-level model: pending pairs per requester, a round-robin
  // pointer, and one outstanding response with the cycle it was granted.
  task automatic test_random();
    int mptr = 0, outst = 0, gcyc = 0, g, idx, left;
    bit done = 0;
    logic [NREQ-1:0] exp_rdy;
    logic [NBIT:0]   t;
    logic [NBIT:0]   exp_t;
    int              exp_id = 0;
    logic [NBIT-1:0] v;
    exp_t = '0;
    do_reset();
    for (int i = 0; i < NREQ; i++)
      for (int n = 0; n < 6; n++) begin
        case ($urandom % 4)
          0: v = '1;
          1: v = 32'h8000_0000;
          default: v = $urandom;
        endcase
        qa[i].push_back(v);
        qb[i].push_back($urandom);
      end
    for (int cyc = 0; cyc < 800 && !done; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (qa[i].size() > 0) begin
          set_op(i, qa[i][0], qb[i][0]);
          req_valid[i] = ($urandom % 4) != 0;
        end else begin
          set_op(i, $urandom, $urandom);
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom % 3) != 0;
      #1;
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
        idx = (mptr + k) % NREQ;
        if (g < 0 && req_valid[idx]) g = idx;
      end
      exp_rdy = (outst == 0 && g >= 0) ? (NREQ'(1) << g) : '0;
      total++; if (busy !== (outst != 0)) begin bad++; $display("FAIL rnd_busy c%0d got=%b exp=%0d", cyc, busy, outst); end
      total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL rnd_ready c%0d got=%b exp=%b", cyc, req_ready, exp_rdy); end
      total++; if (rsp_valid !== (outst != 0 && cyc >= gcyc + 2))
        begin bad++; $display("FAIL rnd_rsp_valid c%0d got=%b", cyc, rsp_valid); end
      if (outst != 0 && cyc >= gcyc + 2) begin
        total++; if (rsp_sum !== exp_t[NBIT-1:0] || rsp_cout !== exp_t[NBIT] || rsp_id !== IDW'(exp_id))
          begin bad++; $display("FAIL rnd_rsp c%0d got=id%0d %h/%b exp=id%0d %h/%b", cyc, rsp_id, rsp_sum, rsp_cout, exp_id, exp_t[NBIT-1:0], exp_t[NBIT]); end
      end
      if (outst != 0 && cyc >= gcyc + 2 && rsp_ready) outst = 0;
      else if (outst == 0 && g >= 0) begin
        t = {1'b0, qa[g][0]} + {1'b0, qb[g][0]};
        exp_t = t; exp_id = g;
        void'(qa[g].pop_front()); void'(qb[g].pop_front());
        outst = 1; gcyc = cyc; mptr = (g + 1) % NREQ;
      end
      left = 0;
      for (int i = 0; i < NREQ; i++) left += qa[i].size();
      if (left == 0 && outst == 0) done = 1;
      @(negedge clk);
    end
    total++; if (!done) begin bad++; $display("FAIL rnd_timeout left pending work"); end
    req_valid = '0;
  endtask

  initial begin
    rst_n = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_overflow();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_sparse_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter NBIT, default 32, operand and sum width in bits.
REQ-002 Parameter NREQ, default 4, number of requesters (2..8); IDW = max(1, clog2(NREQ)).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 req_valid  input  NREQ  bit i: requester i presents an operand pair.
REQ-006 req_a  input  NREQ*NBIT  operand A; requester i occupies bits [i*NBIT +: NBIT].
REQ-007 req_b  input  NREQ*NBIT  operand B, same packing as req_a.
REQ-008 req_ready  output  NREQ  one-hot grant; bit i high means requester i is accepted this cycle.
REQ-009 rsp_valid  output  1  result registers hold a valid response.
REQ-010 rsp_ready  input  1  downstream accepts the response.
REQ-011 rsp_sum  output  NBIT  (a + b) mod 2^NBIT.
REQ-012 rsp_cout  output  1  carry out of bit NBIT-1.
REQ-013 rsp_id  output  IDW  index of the requester that owns the response.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 The block SHALL contain exactly one NBIT adder datapath (carry-in 0), shared by all requesters.
REQ-016 FSM states SHALL be IDLE, ADD and RESP; the encoding is free.
REQ-017 In IDLE with any req_valid bit set, the block SHALL grant one requester, latch its req_a, req_b and index into operand registers, and move to ADD.
REQ-018 In IDLE with no req_valid bit set, the block SHALL stay in IDLE with req_ready all zero.
REQ-019 Grant selection SHALL be round-robin: the first set req_valid bit at or above the priority pointer, wrapping from NREQ-1 to 0.
REQ-020 req_ready SHALL be combinational, asserted only in IDLE, only for the granted bit, and at most one-hot.
REQ-021 On a grant to index g, the priority pointer SHALL become (g+1) mod NREQ; it SHALL not change when no grant occurs.
REQ-022 In ADD, the block SHALL load rsp_sum and rsp_cout from the adder output on the latched operands, load rsp_id, set rsp_valid, and move to RESP.
REQ-023 In RESP, rsp_valid and rsp_sum/rsp_cout/rsp_id SHALL remain stable until rsp_ready is sampled high.
REQ-024 On rsp_valid and rsp_ready both high, the block SHALL clear rsp_valid and return to IDLE on that edge.
REQ-025 Latency: a request accepted at edge T SHALL produce rsp_valid high after edge T+1; the minimum spacing between grants is 3 cycles.
REQ-026 Requesters that are not granted SHALL see req_ready low and are expected to hold req_valid and their operands; no request is dropped or reordered within a requester.
REQ-027 req_valid changes outside IDLE SHALL have no effect on state, operands or pointer.
REQ-028 Overflow SHALL wrap mod 2^NBIT, with the carry reported only on rsp_cout; no saturation.
REQ-029 A requester may deassert req_valid before it is granted; the block SHALL then skip that requester.

Reset
REQ-030 While rst_n is low, the block SHALL be in IDLE with rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, busy=0, req_ready=0, pointer=0, and operand registers at 0.
REQ-031 Reset asserted in ADD or RESP SHALL abort the transaction immediately; no response is produced after reset is released.
REQ-032 After rst_n rises, the first grant SHALL be possible on the first rising edge.

Verification
REQ-033 Single request: NBIT=32, req 0 with a=0x0000_0005, b=0x0000_0003, rsp_ready=1 -> req_ready[0] for 1 cycle, rsp_sum=0x8, cout=0, id=0 two edges later.
REQ-034 Overflow: a=0xFFFF_FFFF, b=0x0000_0001 -> rsp_sum=0x0, rsp_cout=1; a=b=0x8000_0000 -> sum 0, cout 1.
REQ-035 Round-robin: all 4 requesters held valid from reset -> grant order 0,1,2,3,0; each id matches the sum of its operands.
REQ-036 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, req_ready=0, busy=1; rsp_ready=1 -> IDLE on the next edge, next grant one cycle later.
REQ-037 Reset mid-operation: rst_n low in ADD -> all outputs at reset values asynchronously, pointer=0, no rsp_valid after release.
REQ-038 Sparse/wrap: pointer=3 with only req 1 valid -> grant 1, pointer becomes 2.
